idex_stage_reg: RTL
===================

Name: idex_stage_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded ID-stage state each cycle and presents it to EX-stage forwarding and the ALU. When an EX-stage load feeds the ID instruction, it inserts a one-cycle bubble and freezes IF/ID. It also honours branch flush from EX and a global memory stall.

Parameters:
NOP_INSTR, 32'h00000013, instruction word loaded on bubble/flush/reset (ADDI x0,x0,0)
CNT_W, 16, width of saturating load-use stall counter

Ports:
clk  input  1  core clock; all state on rising edge
rst  input  1  asynchronous active-high reset
Instruction_ID  input  32  instruction in ID
PC_ID  input  32  PC of ID instruction
RegData1_ID  input  32  rs1 read data (regfile write-before-read bypass is internal to the regfile)
RegData2_ID  input  32  rs2 read data
Imm_ID  input  32  decoded immediate
RegWriteEnable_ID  input  1  ID instruction writes rd
MemRead_ID  input  1  ID instruction is a load
MemWrite_ID  input  1  ID instruction is a store
Valid_ID  input  1  ID holds a real instruction
flush_EX  input  1  taken branch/jump resolved in EX; kill ID instruction
stall_ext  input  1  global memory stall; hold all pipeline registers
Instruction_IDEX_out  output  32  registered instruction to EX
PC_IDEX_out  output  32  registered PC
RegData1_IDEX_out  output  32  registered rs1 data (pre-forwarding)
RegData2_IDEX_out  output  32  registered rs2 data (pre-forwarding)
Imm_IDEX_out  output  32  registered immediate
RegWriteEnable_IDEX_out  output  1  registered write enable
MemRead_IDEX_out  output  1  registered load flag
MemWrite_IDEX_out  output  1  registered store flag
Valid_IDEX_out  output  1  registered valid
stall_IFID  output  1  combinational; hold PC and IF/ID this cycle
loadUse_count  output  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (async, immediate): Instruction_IDEX_out=NOP_INSTR; all other registered outputs 0; loadUse_count=0. stall_IFID is 0 whenever Valid_IDEX_out=0.
- Source-use decode from Instruction_ID[6:0]:
  - uses_rs1 = 1 except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2 = 1 only for R 0110011, S 0100011, B 1100011.
- load_use = Valid_ID & Valid_IDEX_out & MemRead_IDEX_out & (rd_EX != 0) & ((uses_rs1 & rd_EX==rs1_ID) | (uses_rs2 & rd_EX==rs2_ID)).
  - rd_EX = Instruction_IDEX_out[11:7]; rs1_ID = Instruction_ID[19:15]; rs2_ID = Instruction_ID[24:20].
- stall_IFID = load_use & ~flush_EX (combinational, no register delay).
- Per-edge update, priority high to low:
  1. stall_ext=1: all registers hold, including the counter.
  2. flush_EX=1: load a bubble, stall_IFID=0, counter unchanged.
  3. load_use=1: load a bubble, counter += 1 (saturates at all-ones).
  4. Otherwise: capture all *_ID inputs; Valid_IDEX_out=Valid_ID.
- Bubble contents: Instruction=NOP_INSTR; RegWriteEnable, MemRead, MemWrite, Valid=0; PC, data and Imm=0.
- Load-use costs exactly one bubble. Next cycle the load sits in MEM and downstream forwarding supplies its result, so load_use deasserts.
- Valid_ID=0 never raises load_use and is captured as Valid=0. Control fields are still captured as given; the upstream stage drives zeros.
- rd_EX=x0 never stalls. A store's rs2 matching the load's rd stalls, because this core has no MEM->MEM forward.
- Latency: ID to EX output is 1 cycle when no hazard.

Test Plan:
- Reset mid-run: registers hold addi x5 with Valid=1, then assert rst asynchronously -> outputs go to NOP_INSTR/0 before the next edge; loadUse_count=0.
- Load-use: EX=lw x6,0(x1) valid; ID=add x7,x6,x2 -> stall_IFID=1; next edge EX=NOP with Valid=0 and count=1; following edge captures add with stall_IFID=0.
- No false stall: EX=lw x6; ID=lui x6,0x1 -> stall=0. ID=addi x7,x6,1 with EX=lw x0 -> stall=0. ID=add x7,x6,x2 with EX MemRead=0 -> stall=0.
- Flush beats hazard: lw x6 in EX, add x7,x6,x2 in ID, flush_EX=1 -> stall_IFID=0; bubble loaded; count unchanged.
- stall_ext hold: set stall_ext=1 for 3 cycles during a load-use condition -> outputs and count frozen. On release, exactly one bubble is inserted and count increments by 1.
- Counter saturation: CNT_W=4, force 17 load-use events -> loadUse_count stays at 4'hF.

Source files
------------

// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bus: decoded ID-stage inputs, registered EX-side outputs,
// the IF/ID freeze request and the load-use bubble counter.
interface idex_stage_reg_if #(
  parameter int CNT_W = 16
);
  // ID-stage side
  logic [31:0]      Instruction_ID;
  logic [31:0]      PC_ID;
  logic [31:0]      RegData1_ID;
  logic [31:0]      RegData2_ID;
  logic [31:0]      Imm_ID;
  logic             RegWriteEnable_ID;
  logic             MemRead_ID;
  logic             MemWrite_ID;
  logic             Valid_ID;
  logic             flush_EX;
  logic             stall_ext;
  // EX-stage side
  logic [31:0]      Instruction_IDEX_out;
  logic [31:0]      PC_IDEX_out;
  logic [31:0]      RegData1_IDEX_out;
  logic [31:0]      RegData2_IDEX_out;
  logic [31:0]      Imm_IDEX_out;
  logic             RegWriteEnable_IDEX_out;
  logic             MemRead_IDEX_out;
  logic             MemWrite_IDEX_out;
  logic             Valid_IDEX_out;
  logic             stall_IFID;
  logic [CNT_W-1:0] loadUse_count;

  modport master (
    output Instruction_ID, PC_ID, RegData1_ID, RegData2_ID, Imm_ID,
           RegWriteEnable_ID, MemRead_ID, MemWrite_ID, Valid_ID,
           flush_EX, stall_ext,
    input  Instruction_IDEX_out, PC_IDEX_out, RegData1_IDEX_out,
           RegData2_IDEX_out, Imm_IDEX_out, RegWriteEnable_IDEX_out,
           MemRead_IDEX_out, MemWrite_IDEX_out, Valid_IDEX_out,
           stall_IFID, loadUse_count
  );

  modport slave (
    input  Instruction_ID, PC_ID, RegData1_ID, RegData2_ID, Imm_ID,
           RegWriteEnable_ID, MemRead_ID, MemWrite_ID, Valid_ID,
           flush_EX, stall_ext,
    output Instruction_IDEX_out, PC_IDEX_out, RegData1_IDEX_out,
           RegData2_IDEX_out, Imm_IDEX_out, RegWriteEnable_IDEX_out,
           MemRead_IDEX_out, MemWrite_IDEX_out, Valid_IDEX_out,
           stall_IFID, loadUse_count
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rd feeds the ID instruction costs one bubble and
// freezes IF/ID for that cycle; EX flush and the global stall override it.
module idex_stage_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  idex_stage_reg_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        rwe;
    logic        mrd;
    logic        mwr;
    logic        vld;
  } idex_t;

  idex_t            r_q;
  logic [CNT_W-1:0] r_cnt;

  idex_t      w_in;
  idex_t      w_bubble;
  logic [6:0] w_op;
  logic [4:0] w_rd_ex;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_load_use;

  // ID-stage payload and the bubble image
  always_comb begin
    w_in       = '{instr: bus.Instruction_ID, pc: bus.PC_ID,
                   rd1: bus.RegData1_ID, rd2: bus.RegData2_ID,
                   imm: bus.Imm_ID, rwe: bus.RegWriteEnable_ID,
                   mrd: bus.MemRead_ID, mwr: bus.MemWrite_ID,
                   vld: bus.Valid_ID};
    w_bubble       = '0;
    w_bubble.instr = NOP_INSTR;
  end

  // source-register usage of the ID instruction and load-use detect
  always_comb begin
    w_op       = bus.Instruction_ID[6:0];
    w_rd_ex    = r_q.instr[11:7];
    w_uses_rs1 = !(w_op == OP_LUI || w_op == OP_AUIPC || w_op == OP_JAL);
    w_uses_rs2 = (w_op == OP_R || w_op == OP_STORE || w_op == OP_BRANCH);
    // stores stall on rs2 too: there is no MEM->MEM forward path
    w_load_use = bus.Valid_ID && r_q.vld && r_q.mrd && (w_rd_ex != 5'd0) &&
                 ((w_uses_rs1 && (w_rd_ex == bus.Instruction_ID[19:15])) ||
                  (w_uses_rs2 && (w_rd_ex == bus.Instruction_ID[24:20])));
  end

  // stage register: global stall > flush > load-use bubble > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= w_bubble;
    end else if (!bus.stall_ext) begin
      if (bus.flush_EX || w_load_use) r_q <= w_bubble;
      else                            r_q <= w_in;
    end
  end

  // saturating count of bubbles caused by load-use (flush ones excluded)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!bus.stall_ext && !bus.flush_EX && w_load_use &&
                 (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.Instruction_IDEX_out    = r_q.instr;
  assign bus.PC_IDEX_out             = r_q.pc;
  assign bus.RegData1_IDEX_out       = r_q.rd1;
  assign bus.RegData2_IDEX_out       = r_q.rd2;
  assign bus.Imm_IDEX_out            = r_q.imm;
  assign bus.RegWriteEnable_IDEX_out = r_q.rwe;
  assign bus.MemRead_IDEX_out        = r_q.mrd;
  assign bus.MemWrite_IDEX_out       = r_q.mwr;
  assign bus.Valid_IDEX_out          = r_q.vld;
  assign bus.stall_IFID              = w_load_use && !bus.flush_EX;
  assign bus.loadUse_count           = r_cnt;

endmodule
